// File: rtl/uart_pkg.sv
// Shared constants and FSM encoding for the FIFO-buffered UART transmitter.
package uart_pkg;

  localparam int unsigned OVERSAMPLE = 8;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// Circular-buffer synchronous FIFO; the extra level bit separates full from empty.
module uart_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // Storage needs no reset; pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_tx_fifo_cfg.sv
// UART transmitter fed from an AXI-Stream FIFO, with per-frame latched
// prescale, parity and stop-bit settings.
module uart_tx_fifo_cfg
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_WIDTH-1:0]         s_axis_tdata,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  output logic                          txd,
  output logic                          busy,
  input  logic [15:0]                   prescale,
  input  logic [1:0]                    parity_mode,
  input  logic                          stop_bits,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned CNT_W = 19;
  localparam int unsigned IDX_W = $clog2(DATA_WIDTH);

  tx_state_e             state;
  logic [DATA_WIDTH-1:0] shreg;
  logic [IDX_W-1:0]      bit_idx;
  logic [CNT_W-1:0]      cnt;
  logic [CNT_W-1:0]      reload;
  logic                  par_en;
  logic                  par_bit;
  logic                  two_stop;
  logic                  stop_second;

  logic [DATA_WIDTH-1:0] fifo_dout;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  pop;
  logic [15:0]           ps_eff;
  logic [CNT_W-1:0]      reload_now;

  assign s_axis_tready = !fifo_full;
  assign pop           = (state == ST_IDLE) && !fifo_empty;
  assign ps_eff        = (prescale == 16'd0) ? 16'd1 : prescale;
  assign reload_now    = CNT_W'(ps_eff) * CNT_W'(OVERSAMPLE) - CNT_W'(1);

  uart_sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (s_axis_tvalid),
    .pop   (pop),
    .din   (s_axis_tdata),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // txd and busy follow the state one cycle later, keeping every bit period exact.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      txd         <= 1'b1;
      busy        <= 1'b0;
      shreg       <= '0;
      bit_idx     <= '0;
      cnt         <= '0;
      reload      <= '0;
      par_en      <= 1'b0;
      par_bit     <= 1'b0;
      two_stop    <= 1'b0;
      stop_second <= 1'b0;
    end else begin
      busy <= (state != ST_IDLE) || (fifo_level != '0);
      case (state)
        ST_START:  txd <= 1'b0;
        ST_DATA:   txd <= shreg[0];
        ST_PARITY: txd <= par_bit;
        default:   txd <= 1'b1;
      endcase

      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            shreg    <= fifo_dout;
            reload   <= reload_now;
            cnt      <= reload_now;
            par_en   <= (parity_mode == PAR_EVEN) || (parity_mode == PAR_ODD);
            par_bit  <= (^fifo_dout) ^ (parity_mode == PAR_ODD);
            two_stop <= stop_bits;
            state    <= ST_START;
          end
        end
        ST_START: begin
          if (cnt == '0) begin
            cnt     <= reload;
            bit_idx <= '0;
            state   <= ST_DATA;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_DATA: begin
          if (cnt == '0) begin
            cnt   <= reload;
            shreg <= shreg >> 1;
            if (bit_idx == IDX_W'(DATA_WIDTH - 1)) begin
              stop_second <= 1'b0;
              state       <= par_en ? ST_PARITY : ST_STOP;
            end else begin
              bit_idx <= bit_idx + IDX_W'(1);
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_PARITY: begin
          if (cnt == '0) begin
            cnt   <= reload;
            state <= ST_STOP;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_STOP: begin
          if (cnt == '0) begin
            if (two_stop && !stop_second) begin
              stop_second <= 1'b1;
              cnt         <= reload;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_cfg.sv
// Directed bench for uart_tx_fifo_cfg (DATA_WIDTH=8, FIFO_DEPTH=4); samples on the falling edge.
module tb_uart_tx_fifo_cfg;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  s_axis_tdata = 8'h00;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic        txd;
  logic        busy;
  logic [15:0] prescale = 16'd6;
  logic [1:0]  parity_mode = 2'b00;
  logic        stop_bits = 1'b0;
  logic [2:0]  fifo_level;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;

  int   idx;
  int   bad_full;
  int   zeros;
  bit   saw_full;
  logic rdy;
  int   st [6];
  int   sa, sb;

  uart_tx_fifo_cfg #(.DATA_WIDTH(8), .FIFO_DEPTH(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .txd           (txd),
    .busy          (busy),
    .prescale      (prescale),
    .parity_mode   (parity_mode),
    .stop_bits     (stop_bits),
    .fifo_level    (fifo_level)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("check %s failed", tag);
    end
  endtask

  task automatic push_word(input logic [7:0] d);
    chk("push_tready", s_axis_tready, 1'b1);
    s_axis_tdata  = d;
    s_axis_tvalid = 1'b1;
    @(negedge clk);
    s_axis_tvalid = 1'b0;
  endtask

  task automatic wait_start(input string tag, output int t0);
    bit found;
    found = 1'b0;
    for (int t = 0; t < 3000 && !found; t++) begin
      @(negedge clk);
      if (txd === 1'b0) found = 1'b1;
    end
    chk({tag, "_start_seen"}, found, 1'b1);
    t0 = cyc;
  endtask

  // Entered on the first low cycle of the start bit; samples mid-bit.
  task automatic frame_body(input string tag, input logic [7:0] d, input bit pe,
                            input logic pv, input int stops, input int bl);
    repeat (bl / 2) @(negedge clk);
    chk({tag, "_start"}, txd, 1'b0);
    for (int i = 0; i < 8; i++) begin
      repeat (bl) @(negedge clk);
      chk($sformatf("%s_d%0d", tag, i), txd, d[i]);
    end
    if (pe) begin
      repeat (bl) @(negedge clk);
      chk({tag, "_parity"}, txd, pv);
    end
    for (int s = 0; s < stops; s++) begin
      repeat (bl) @(negedge clk);
      chk($sformatf("%s_stop%0d", tag, s), txd, 1'b1);
    end
  endtask

  task automatic expect_frame(input string tag, input logic [7:0] d, input bit pe,
                              input logic pv, input int stops, input int bl, output int t0);
    wait_start(tag, t0);
    frame_body(tag, d, pe, pv, stops, bl);
  endtask

  initial begin
    // Reset, then idle line.
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_txd", txd, 1'b1);
      chk("idle_busy", busy, 1'b0);
      chk("idle_tready", s_axis_tready, 1'b1);
      chk("idle_level", fifo_level, 3'd0);
    end

    // 8N1 at prescale 6: exact start latency and 48-cycle bits.
    prescale = 16'd6;
    chk("t2_tready", s_axis_tready, 1'b1);
    s_axis_tdata = 8'h55; s_axis_tvalid = 1'b1;
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    chk("t2_level1", fifo_level, 3'd1);
    chk("t2_txd_e1", txd, 1'b1);
    @(negedge clk);
    chk("t2_txd_e2", txd, 1'b1);
    chk("t2_busy", busy, 1'b1);
    @(negedge clk);
    chk("t2_txd_fall", txd, 1'b0);
    frame_body("t2", 8'h55, 1'b0, 1'b0, 1, 48);
    repeat (23) @(negedge clk);
    chk("t2_last_stop_txd", txd, 1'b1);
    chk("t2_last_stop_busy", busy, 1'b1);
    repeat (2) @(negedge clk);
    chk("t2_busy_drop", busy, 1'b0);
    chk("t2_level0", fifo_level, 3'd0);

    // Back-to-back streaming with tvalid held high.
    prescale = 16'd1;
    repeat (4) @(negedge clk);
    idx = 0; bad_full = 0; saw_full = 1'b0;
    fork
      begin
        s_axis_tdata = 8'h11; s_axis_tvalid = 1'b1;
        for (int t = 0; t < 3000 && idx < 6; t++) begin
          if (fifo_level == 3'd4) begin
            saw_full = 1'b1;
            if (s_axis_tready) bad_full++;
          end
          rdy = s_axis_tready;
          @(negedge clk);
          if (rdy) idx++;
          if (idx < 6) s_axis_tdata = 8'((idx + 1) * 17);
          else s_axis_tvalid = 1'b0;
        end
        s_axis_tvalid = 1'b0;
      end
      begin
        for (int i = 0; i < 6; i++)
          expect_frame($sformatf("t3_f%0d", i), 8'((i + 1) * 17), 1'b0, 1'b0, 1, 8, st[i]);
      end
    join
    chk("t3_accepts", idx, 6);
    chk("t3_saw_full", saw_full, 1'b1);
    chk("t3_tready_when_full", bad_full, 0);
    for (int i = 0; i < 5; i++) chk($sformatf("t3_gap%0d", i), st[i+1] - st[i], 81);
    zeros = 0;
    repeat (100) begin
      @(negedge clk);
      if (txd !== 1'b1) zeros++;
    end
    chk("t3_no_extra_frame", zeros, 0);
    chk("t3_level0", fifo_level, 3'd0);

    // Even parity then odd parity with two stop bits.
    parity_mode = 2'b01; stop_bits = 1'b0;
    push_word(8'hA7);
    wait_start("t4_f0", sa);
    parity_mode = 2'b10; stop_bits = 1'b1;
    s_axis_tdata = 8'hA7; s_axis_tvalid = 1'b1;
    fork
      frame_body("t4_f0", 8'hA7, 1'b1, 1'b1, 1, 8);
      begin @(negedge clk); s_axis_tvalid = 1'b0; end
    join
    expect_frame("t4_f1", 8'hA7, 1'b1, 1'b0, 2, 8, sb);
    chk("t4_gap", sb - sa, 89);
    repeat (3) @(negedge clk);
    chk("t4_busy_2stop", busy, 1'b1);
    repeat (2) @(negedge clk);
    chk("t4_busy_drop", busy, 1'b0);

    // Settings changed mid-frame only affect the next frame.
    parity_mode = 2'b00; stop_bits = 1'b0; prescale = 16'd2;
    push_word(8'h3C);
    push_word(8'hC3);
    wait_start("t5_f0", sa);
    prescale = 16'd1; parity_mode = 2'b01;
    frame_body("t5_f0", 8'h3C, 1'b0, 1'b0, 1, 16);
    expect_frame("t5_f1", 8'hC3, 1'b1, 1'b0, 1, 8, sb);
    chk("t5_gap", sb - sa, 161);
    repeat (10) @(negedge clk);

    // Reset mid-DATA with three words queued.
    parity_mode = 2'b00;
    push_word(8'h81);
    push_word(8'h82);
    push_word(8'h83);
    push_word(8'h84);
    wait_start("t6", sa);
    repeat (32) @(negedge clk);
    chk("t6_level_before", fifo_level, 3'd3);
    chk("t6_busy_before", busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t6_txd", txd, 1'b1);
    chk("t6_level", fifo_level, 3'd0);
    chk("t6_busy", busy, 1'b0);
    chk("t6_tready", s_axis_tready, 1'b1);
    zeros = 0;
    repeat (200) begin
      @(negedge clk);
      if (txd !== 1'b1 || busy !== 1'b0) zeros++;
    end
    chk("t6_nothing_sent", zeros, 0);
    chk("t6_level_after", fifo_level, 3'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo_cfg.md
Name: uart_tx_fifo_cfg

Overview:
- Next-generation UART transmitter: AXI-Stream byte input, parametrised data width, internal transmit FIFO, run-time parity and stop-bit selection.
- Sits between a stream producer and the serial pin, replacing the single-buffer transmitter.
- s_axis_tready is a pure function of FIFO occupancy, so back-to-back streaming never drops or duplicates words.

Parameters:
DATA_WIDTH, 8, data bits per frame (5..9).
FIFO_DEPTH, 4, transmit FIFO entries; power of two, 2..64.

Ports:
clk  in  1  system clock.
rst  in  1  synchronous active-high reset.
s_axis_tdata  in  DATA_WIDTH  word to transmit, LSB sent first.
s_axis_tvalid  in  1  producer has a word.
s_axis_tready  out  1  FIFO can accept a word.
txd  out  1  serial output, idle high.
busy  out  1  a frame is on the line or the FIFO is non-empty.
prescale  in  16  bit period = prescale*8 clk cycles.
parity_mode  in  2  00 none, 01 even, 10 odd, 11 treated as none.
stop_bits  in  1  0 one stop bit, 1 two stop bits.
fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (rst=1 at any edge, including mid-frame):
  - FIFO emptied; FSM to IDLE.
  - txd=1, busy=0, fifo_level=0, s_axis_tready=1 from the first edge after reset.
  - A partially sent frame is abandoned; no glitch below idle level after reset.
- Handshake:
  - Accept when s_axis_tvalid && s_axis_tready at a rising edge.
  - s_axis_tready = (fifo_level != FIFO_DEPTH), registered-state based only.
  - s_axis_tready never depends combinationally on s_axis_tvalid.
  - Simultaneous push and pop when full: push refused (tready=0), pop proceeds, tready=1 next cycle.
  - Simultaneous push and pop when non-full: level unchanged.
- FIFO:
  - Circular buffer; pointers wrap modulo FIFO_DEPTH.
  - Empty/full distinguished by the extra level bit.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: if FIFO non-empty, pop the head word into the shift register.
    - Latch prescale, parity_mode and stop_bits into frame-local registers; these are never re-sampled mid-frame.
    - Go to START.
  - START: txd=0 for one bit period, then DATA.
  - DATA: shift out DATA_WIDTH bits, LSB first, one bit period each. Then PARITY if latched mode is 01/10, else STOP.
  - PARITY: txd = XOR of data bits (even) or its inverse (odd), one bit period.
  - STOP: txd=1 for one or two bit periods. Then IDLE; if the FIFO is non-empty, the next frame's start bit begins with no extra idle cycle beyond the IDLE dispatch cycle.
- Timing:
  - Bit counter reloads with latched prescale*8 - 1 and counts down.
  - prescale=0 is treated as 1 (8-cycle bits).
  - A word accepted at edge k into an empty FIFO with FSM idle: txd falls after edge k+2.
  - Frame length in bit periods = 1 + DATA_WIDTH + parity(0/1) + stop(1/2).
- busy = (state != IDLE) || (fifo_level != 0). Registered; asserts the cycle after the first accept.
- Prescale multiply: 19-bit result, no overflow.

Decomposition:
- Package uart_pkg holds:
  - parity constants PAR_NONE=2'b00, PAR_EVEN=2'b01, PAR_ODD=2'b10;
  - FSM state encoding;
  - OVERSAMPLE=8.
- One sub-module, uart_sync_fifo (parameters WIDTH, DEPTH; ports push, pop, full, empty, level, dout). The transmitter FSM and bit timer stay in uart_tx_fifo_cfg.

Test Plan:
1. Reset then idle 20 cycles -> txd=1, busy=0, s_axis_tready=1, fifo_level=0 throughout.
2. prescale=6, 8N1, push 8'h55 -> txd low after 2 edges for 48 cycles, then bits 1,0,1,0,1,0,1,0 at 48 cycles each, one 48-cycle stop bit; busy drops after the stop bit.
3. Hold tvalid with 8'h11, 8'h22 ... 8'h66 back-to-back, FIFO_DEPTH=4 -> exactly 6 accepts, tready low while level=4. Decoded line order is 11,22,33,44,55,66 with no gaps between frames beyond the dispatch cycle.
4. Push 8'hA7 with parity_mode=01, then 8'hA7 with parity_mode=10 and stop_bits=1 -> parity bits 1 then 0. Second frame shows a 2-bit-period stop.
5. Change parity_mode and prescale mid-frame -> the current frame is unaffected; the next frame uses the new values.
6. Assert rst for 1 cycle mid-DATA with 3 words queued -> txd=1 the next cycle, fifo_level=0, busy=0; none of the queued words are ever transmitted.
